// File: rtl/buzzer_pkg.sv
// Shared definitions for the N-channel quiz buzzer.
//   state_t : round state (idle, armed, flashing winner, holding winner)
//   CW()    : index width for N channels, never less than one bit
//   CNT_W() : width of a counter whose largest value is max_val
package buzzer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FLASH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    function automatic int CW(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int CNT_W(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/buzzer_arb_n_prio_pick.sv
// Combinational priority selector.
//   req     : request mask, one bit per channel
//   ptr     : previous winner; rotating mode starts its search at ptr+1
//   gnt_vld : at least one request is set
//   gnt_idx : selected channel index
// TIE_RR=0 always starts the search at channel 0 (lowest index wins).
module prio_pick
    import buzzer_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int TIE_RR = 0,
    localparam int IDX_W = CW(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    int w_start;

    always_comb begin
        w_start = (TIE_RR != 0) ? (int'(ptr) + 1) % N_CH : 0;
    end

    // Walk the offsets from farthest to nearest so the nearest set
    // request (in search order) is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int o = N_CH - 1; o >= 0; o--) begin
            int c;
            c = (w_start + o) % N_CH;
            if (req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/buzzer_arb_n.sv
// N-channel quiz buzzer arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   tr_btn     : per-channel single-cycle press pulses
//   tr_arm     : host pulse opening the round
//   tr_clr     : host pulse ending the round and clearing fouls
//   led        : per-channel lamps (winner flashes, then steady)
//   buzz       : high while the winner's lamp flashes
//   win_vld    : a winner is latched
//   win_idx    : winner channel index
//   foul       : sticky mask of channels locked out this round
//   tr_win     : one-cycle pulse when a winner is latched
//   tr_timeout : one-cycle pulse when the answer window expires
module buzzer_arb_n
    import buzzer_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FLA_CMAX   = 5000000,
    parameter int FLA_CNT    = 3,
    parameter int ANS_CMAX   = 0,
    parameter int EARLY_LOCK = 1,
    parameter int TIE_RR     = 0,
    localparam int IDX_W     = CW(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  tr_btn,
    input  logic             tr_arm,
    input  logic             tr_clr,
    output logic [N_CH-1:0]  led,
    output logic             buzz,
    output logic             win_vld,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_CH-1:0]  foul,
    output logic             tr_win,
    output logic             tr_timeout
);

    localparam int FW = CNT_W(FLA_CMAX - 1);
    localparam int HW = CNT_W(2 * FLA_CNT - 1);
    localparam int AW = CNT_W((ANS_CMAX > 0) ? ANS_CMAX - 1 : 0);

    state_t           r_state, w_state_nxt;
    logic [FW-1:0]    r_fcnt, w_fcnt_nxt;
    logic [HW-1:0]    r_hcnt, w_hcnt_nxt;
    logic [AW-1:0]    r_acnt, w_acnt_nxt;
    logic [N_CH-1:0]  r_led, w_led_nxt;
    logic             r_buzz, w_buzz_nxt;
    logic             r_win_vld, w_win_vld_nxt;
    logic [IDX_W-1:0] r_win_idx, w_win_idx_nxt;
    logic [N_CH-1:0]  r_foul, w_foul_nxt;
    logic             r_tr_win, w_tr_win_nxt;
    logic             r_tr_to, w_tr_to_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;

    logic [N_CH-1:0]  w_elig;
    logic             w_gnt_vld;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [N_CH-1:0]  w_gnt_oh;
    logic [N_CH-1:0]  w_win_oh;
    logic             w_fla_wrap;
    logic             w_fla_done;
    logic             w_ans_exp;

    assign w_elig   = tr_btn & ~r_foul;
    assign w_gnt_oh = N_CH'(1) << w_gnt_idx;
    assign w_win_oh = N_CH'(1) << r_win_idx;

    assign w_fla_wrap = (r_fcnt == FW'(FLA_CMAX - 1));
    assign w_fla_done = w_fla_wrap && (r_hcnt == HW'(2 * FLA_CNT - 1));
    // Answer counter is 0 on the tr_win cycle, so hitting ANS_CMAX-1
    // makes the timeout land exactly ANS_CMAX cycles after the win.
    assign w_ans_exp  = (ANS_CMAX > 0) &&
                        (r_acnt == AW'((ANS_CMAX > 0) ? ANS_CMAX - 1 : 0));

    prio_pick #(
        .N_CH   (N_CH),
        .TIE_RR (TIE_RR)
    ) u_pick (
        .req     (w_elig),
        .ptr     (r_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_fcnt_nxt    = r_fcnt;
        w_hcnt_nxt    = r_hcnt;
        w_acnt_nxt    = r_acnt;
        w_led_nxt     = r_led;
        w_buzz_nxt    = r_buzz;
        w_win_vld_nxt = r_win_vld;
        w_win_idx_nxt = r_win_idx;
        w_foul_nxt    = r_foul;
        w_ptr_nxt     = r_ptr;
        w_tr_win_nxt  = 1'b0;
        w_tr_to_nxt   = 1'b0;

        if (tr_clr) begin
            // Clear outranks arm, presses and a coincident timeout.
            w_state_nxt   = S_IDLE;
            w_led_nxt     = '0;
            w_buzz_nxt    = 1'b0;
            w_win_vld_nxt = 1'b0;
            w_foul_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (EARLY_LOCK != 0) begin
                        w_foul_nxt = r_foul | tr_btn;
                    end
                    if (tr_arm) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_gnt_vld) begin
                        w_state_nxt   = S_FLASH;
                        w_tr_win_nxt  = 1'b1;
                        w_win_vld_nxt = 1'b1;
                        w_win_idx_nxt = w_gnt_idx;
                        w_led_nxt     = w_gnt_oh;
                        w_buzz_nxt    = 1'b1;
                        w_fcnt_nxt    = '0;
                        w_hcnt_nxt    = '0;
                        w_acnt_nxt    = '0;
                        if (TIE_RR != 0) begin
                            w_ptr_nxt = w_gnt_idx;
                        end
                    end
                end
                S_FLASH, S_HOLD: begin
                    if (w_ans_exp) begin
                        // Rebound: lock out the silent winner and reopen.
                        w_state_nxt   = S_ARMED;
                        w_tr_to_nxt   = 1'b1;
                        w_foul_nxt    = r_foul | w_win_oh;
                        w_led_nxt     = '0;
                        w_buzz_nxt    = 1'b0;
                        w_win_vld_nxt = 1'b0;
                    end else begin
                        if (ANS_CMAX > 0) begin
                            w_acnt_nxt = r_acnt + AW'(1);
                        end
                        if (r_state == S_FLASH) begin
                            if (w_fla_done) begin
                                w_state_nxt = S_HOLD;
                                w_led_nxt   = w_win_oh;
                                w_buzz_nxt  = 1'b0;
                                w_fcnt_nxt  = '0;
                                w_hcnt_nxt  = '0;
                            end else if (w_fla_wrap) begin
                                w_led_nxt  = r_led ^ w_win_oh;
                                w_fcnt_nxt = '0;
                                w_hcnt_nxt = r_hcnt + HW'(1);
                            end else begin
                                w_fcnt_nxt = r_fcnt + FW'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_fcnt    <= '0;
            r_hcnt    <= '0;
            r_acnt    <= '0;
            r_led     <= '0;
            r_buzz    <= 1'b0;
            r_win_vld <= 1'b0;
            r_win_idx <= '0;
            r_foul    <= '0;
            r_tr_win  <= 1'b0;
            r_tr_to   <= 1'b0;
            r_ptr     <= IDX_W'(N_CH - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_acnt    <= w_acnt_nxt;
            r_led     <= w_led_nxt;
            r_buzz    <= w_buzz_nxt;
            r_win_vld <= w_win_vld_nxt;
            r_win_idx <= w_win_idx_nxt;
            r_foul    <= w_foul_nxt;
            r_tr_win  <= w_tr_win_nxt;
            r_tr_to   <= w_tr_to_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign led        = r_led;
    assign buzz       = r_buzz;
    assign win_vld    = r_win_vld;
    assign win_idx    = r_win_idx;
    assign foul       = r_foul;
    assign tr_win     = r_tr_win;
    assign tr_timeout = r_tr_to;

endmodule

// File: tb/tb_buzzer_arb_n.sv
// Bench for buzzer_arb_n: three instances sharing one stimulus stream.
//   d0: fixed priority, 50-cycle answer window, early lockout
//   d1: rotating priority, 50-cycle answer window, early lockout
//   d2: fixed priority, no answer window, no early lockout
module tb_buzzer_arb_n;

    localparam int N  = 4;
    localparam int FM = 5;
    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tr_btn = '0;
    logic       tr_arm = 1'b0;
    logic       tr_clr = 1'b0;

    logic [3:0] led_o  [3];
    logic       buzz_o [3];
    logic       vld_o  [3];
    logic [1:0] idx_o  [3];
    logic [3:0] foul_o [3];
    logic       trw_o  [3];
    logic       trt_o  [3];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    buzzer_arb_n #(.N_CH(N), .FLA_CMAX(FM), .FLA_CNT(FC), .ANS_CMAX(50),
                   .EARLY_LOCK(1), .TIE_RR(0)) u_d0 (
        .clk(clk), .rst(rst), .tr_btn(tr_btn), .tr_arm(tr_arm), .tr_clr(tr_clr),
        .led(led_o[0]), .buzz(buzz_o[0]), .win_vld(vld_o[0]), .win_idx(idx_o[0]),
        .foul(foul_o[0]), .tr_win(trw_o[0]), .tr_timeout(trt_o[0]));

    buzzer_arb_n #(.N_CH(N), .FLA_CMAX(FM), .FLA_CNT(FC), .ANS_CMAX(50),
                   .EARLY_LOCK(1), .TIE_RR(1)) u_d1 (
        .clk(clk), .rst(rst), .tr_btn(tr_btn), .tr_arm(tr_arm), .tr_clr(tr_clr),
        .led(led_o[1]), .buzz(buzz_o[1]), .win_vld(vld_o[1]), .win_idx(idx_o[1]),
        .foul(foul_o[1]), .tr_win(trw_o[1]), .tr_timeout(trt_o[1]));

    buzzer_arb_n #(.N_CH(N), .FLA_CMAX(FM), .FLA_CNT(FC), .ANS_CMAX(0),
                   .EARLY_LOCK(0), .TIE_RR(0)) u_d2 (
        .clk(clk), .rst(rst), .tr_btn(tr_btn), .tr_arm(tr_arm), .tr_clr(tr_clr),
        .led(led_o[2]), .buzz(buzz_o[2]), .win_vld(vld_o[2]), .win_idx(idx_o[2]),
        .foul(foul_o[2]), .tr_win(trw_o[2]), .tr_timeout(trt_o[2]));

    function automatic int ans_of(input int d);
        return (d == 2) ? 0 : 50;
    endfunction
    function automatic bit rr_of(input int d);
        return d == 1;
    endfunction
    function automatic bit el_of(input int d);
        return d != 2;
    endfunction

    // Reference model: a round is either closed, open, or has a winner of
    // a given age (cycles since the tr_win cycle); lamps derive from age.
    bit       m_open [3];
    bit       m_has  [3];
    int       m_age  [3];
    int       m_idx  [3];
    int       m_ptr  [3];
    bit [3:0] m_foul [3];
    bit       m_trw  [3];
    bit       m_trt  [3];

    function automatic int pick(input bit [3:0] e, input int start);
        for (int o = 0; o < N; o++) begin
            if (e[(start + o) % N]) return (start + o) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bit [3:0] el;
            int p;
            m_trw[d] = 1'b0;
            m_trt[d] = 1'b0;
            if (rst) begin
                m_open[d] = 1'b0; m_has[d] = 1'b0; m_age[d] = 0;
                m_idx[d] = 0; m_ptr[d] = N - 1; m_foul[d] = '0;
            end else if (tr_clr) begin
                m_open[d] = 1'b0; m_has[d] = 1'b0; m_foul[d] = '0;
            end else if (m_has[d]) begin
                if (ans_of(d) > 0 && m_age[d] + 1 == ans_of(d)) begin
                    m_trt[d] = 1'b1;
                    m_foul[d][m_idx[d]] = 1'b1;
                    m_has[d] = 1'b0;
                    m_open[d] = 1'b1;
                end else begin
                    m_age[d]++;
                end
            end else if (m_open[d]) begin
                el = tr_btn & ~m_foul[d];
                p = pick(el, rr_of(d) ? (m_ptr[d] + 1) % N : 0);
                if (p >= 0) begin
                    m_has[d] = 1'b1; m_open[d] = 1'b0; m_age[d] = 0;
                    m_idx[d] = p; m_trw[d] = 1'b1;
                    if (rr_of(d)) m_ptr[d] = p;
                end
            end else begin
                if (el_of(d)) m_foul[d] = m_foul[d] | tr_btn;
                if (tr_arm) m_open[d] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                bit [3:0] oh, el;
                bit       bz;
                oh = 4'b0001 << m_idx[d];
                el = '0;
                bz = 1'b0;
                if (m_has[d]) begin
                    if (m_age[d] < 2 * FC * FM) begin
                        bz = 1'b1;
                        el = ((m_age[d] / FM) % 2 == 0) ? oh : 4'b0000;
                    end else begin
                        el = oh;
                    end
                end
                chk($sformatf("d%0d led", d), 32'(led_o[d]), 32'(el));
                chk($sformatf("d%0d buzz", d), 32'(buzz_o[d]), 32'(bz));
                chk($sformatf("d%0d win_vld", d), 32'(vld_o[d]), 32'(m_has[d]));
                chk($sformatf("d%0d win_idx", d), 32'(idx_o[d]), 32'(m_idx[d]));
                chk($sformatf("d%0d foul", d), 32'(foul_o[d]), 32'(m_foul[d]));
                chk($sformatf("d%0d tr_win", d), 32'(trw_o[d]), 32'(m_trw[d]));
                chk($sformatf("d%0d tr_timeout", d), 32'(trt_o[d]), 32'(m_trt[d]));
            end
        end
    end

    // Apply one pulse for one clock; returns on the following negedge,
    // where outputs show the cycle after the pulse was sampled.
    task automatic drive(input logic [3:0] b, input logic a, input logic c);
        tr_btn = b; tr_arm = a; tr_clr = c;
        @(negedge clk);
        tr_btn = '0; tr_arm = 1'b0; tr_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset led", 32'(led_o[0]), 32'h0);
        chk("reset win_vld", 32'(vld_o[0]), 32'h0);
        chk("reset foul", 32'(foul_o[0]), 32'h0);

        // Early press while disarmed fouls ch2 (not on d2).
        drive(4'b0100, 1'b0, 1'b0);
        chk("early foul d0", 32'(foul_o[0]), 32'h4);
        chk("early no win d0", 32'(trw_o[0]), 32'h0);
        chk("early no foul d2", 32'(foul_o[2]), 32'h0);

        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        chk("fouled press ignored d0", 32'(trw_o[0]), 32'h0);
        chk("unfouled press wins d2", 32'(trw_o[2]), 32'h1);

        drive(4'b0010, 1'b0, 1'b0);
        chk("win pulse d0", 32'(trw_o[0]), 32'h1);
        chk("win idx d0", 32'(idx_o[0]), 32'h1);
        chk("win led d0", 32'(led_o[0]), 32'h2);

        // Flash profile and timeout, k = cycles counted from the tr_win cycle.
        for (int k = 1; k <= 52; k++) begin
            if (k <= 25) begin
                chk($sformatf("flash led k=%0d", k), 32'(led_o[0][1]),
                    32'((k <= 5) || (k >= 11 && k <= 15) || (k >= 21)));
                chk($sformatf("flash buzz k=%0d", k), 32'(buzz_o[0]), 32'(k <= 20));
            end
            if (k == 50) chk("no early timeout", 32'(trt_o[0]), 32'h0);
            if (k == 51) begin
                chk("timeout pulse", 32'(trt_o[0]), 32'h1);
                chk("timeout foul", 32'(foul_o[0]), 32'h6);
                chk("timeout led", 32'(led_o[0]), 32'h0);
                chk("timeout win_vld", 32'(vld_o[0]), 32'h0);
                chk("no timeout d2", 32'(vld_o[2]), 32'h1);
            end
            @(negedge clk);
        end

        // Rebound: previous winner locked out, another channel wins.
        drive(4'b0010, 1'b0, 1'b0);
        chk("timed-out winner ignored", 32'(trw_o[0]), 32'h0);
        drive(4'b1000, 1'b0, 1'b0);
        chk("rebound win", 32'(trw_o[0]), 32'h1);
        chk("rebound idx", 32'(idx_o[0]), 32'h3);

        // Clear in the middle of flashing.
        idle(3);
        drive(4'b0000, 1'b0, 1'b1);
        chk("clr led", 32'(led_o[0]), 32'h0);
        chk("clr buzz", 32'(buzz_o[0]), 32'h0);
        chk("clr win_vld", 32'(vld_o[0]), 32'h0);
        chk("clr foul", 32'(foul_o[0]), 32'h0);

        // Clear beats arm in the same cycle.
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0001, 1'b0, 1'b0);
        chk("clr+arm stays idle", 32'(trw_o[0]), 32'h0);
        chk("clr+arm idle foul", 32'(foul_o[0]), 32'h1);
        drive(4'b0000, 1'b0, 1'b1);

        // Ties: fixed gives lowest, rotating moves past the last winner.
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1010, 1'b0, 1'b0);
        chk("tie fixed", 32'(idx_o[0]), 32'h1);
        chk("tie rr first", 32'(idx_o[1]), 32'h1);
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1010, 1'b0, 1'b0);
        chk("tie fixed again", 32'(idx_o[0]), 32'h1);
        chk("tie rr second", 32'(idx_o[1]), 32'h3);

        // Clear on the cycle the window would expire suppresses the pulse.
        idle(49);
        drive(4'b0000, 1'b0, 1'b1);
        chk("clr on timeout: no pulse", 32'(trt_o[0]), 32'h0);
        chk("clr on timeout: win_vld", 32'(vld_o[0]), 32'h0);

        // Long hold, then reset from S_HOLD.
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        chk("rr pick from ptr", 32'(idx_o[1]), 32'h2);
        idle(59);
        chk("no window hold vld", 32'(vld_o[2]), 32'h1);
        chk("no window hold led", 32'(led_o[2]), 32'h4);
        chk("windowed expired", 32'(vld_o[0]), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst hold led", 32'(led_o[2]), 32'h0);
        chk("rst hold win_vld", 32'(vld_o[2]), 32'h0);
        chk("rst foul", 32'(foul_o[0]), 32'h0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1111, 1'b0, 1'b0);
        chk("rr after reset", 32'(idx_o[1]), 32'h0);
        chk("fixed all pressed", 32'(idx_o[0]), 32'h0);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_arb_n.md
Name: buzzer_arb_n

Overview:
- N-channel quiz buzzer, the generalised successor to the two-player buzzer.
- Takes single-cycle press triggers from per-channel button debouncers and arbitrates the first eligible press after the host arms a round.
- Flashes the winner's lamp, then holds it steady, and runs an answer-timeout window that reopens the round to the remaining players.
- Adds early-press (foul) lockout, a selectable fixed or round-robin tie-break, and host arm/clear control.

Parameters:
- N_CH, 4, number of player channels (2..16).
- FLA_CMAX, 5000000, cycles per flash half-period (≥1).
- FLA_CNT, 3, number of full on/off flash periods after a win (≥1).
- ANS_CMAX, 0, answer window in cycles from the win; 0 disables the timeout.
- EARLY_LOCK, 1, 1 = a press while disarmed fouls that channel for the rest of the round.
- TIE_RR, 0, 0 = lowest index wins ties; 1 = rotating priority starting after the previous winner.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tr_btn  in  N_CH  per-channel press pulses, one cycle wide, from button.
- tr_arm  in  1  host pulse: open the round.
- tr_clr  in  1  host pulse: end the round and clear fouls.
- led  out  N_CH  per-channel lamps.
- buzz  out  1  high while flashing.
- win_vld  out  1  a winner is latched.
- win_idx  out  CW  winner index, CW = max(1, clog2(N_CH)).
- foul  out  N_CH  sticky fouled-channel mask.
- tr_win  out  1  one-cycle pulse on a win.
- tr_timeout  out  1  one-cycle pulse when the answer window expires.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: state S_IDLE; led, buzz, win_vld, win_idx, foul, tr_win, tr_timeout all 0; all counters 0; RR pointer = N_CH-1.
- States: S_IDLE, S_ARMED, S_FLASH, S_HOLD.
- tr_clr in any state: next cycle S_IDLE with led, buzz, win_vld and foul cleared. tr_clr has priority over tr_arm and tr_btn in the same cycle. The RR pointer is not cleared.
- S_IDLE:
  - tr_arm → S_ARMED.
  - If EARLY_LOCK=1, foul |= tr_btn, including a press in the same cycle as tr_arm.
  - Otherwise presses are ignored.
- S_ARMED:
  - elig = tr_btn & ~foul.
  - If elig ≠ 0 at cycle t, then at t+1: tr_win=1, win_vld=1, win_idx=pick, led = one-hot(pick), buzz=1, state S_FLASH.
  - pick: TIE_RR=0 → lowest set index. TIE_RR=1 → first set index searching upward from (ptr+1) mod N_CH; ptr := pick on each win.
  - If all channels are fouled, stay in S_ARMED until tr_clr. tr_arm here is a no-op.
- S_FLASH:
  - Half-period counter runs 0..FLA_CMAX-1. On wrap, led[win_idx] toggles.
  - After 2·FLA_CNT half-periods (exactly 2·FLA_CNT·FLA_CMAX cycles from the win), enter S_HOLD with led[win_idx]=1 steady and buzz=0.
  - Presses are ignored.
- S_HOLD: led steady; presses ignored; wait for tr_clr or timeout.
- Answer timer (ANS_CMAX>0):
  - Counts cycles from the win, in S_FLASH or S_HOLD.
  - On the ANS_CMAX-th cycle after the win: tr_timeout=1, foul[win_idx] := 1, led=0, buzz=0, win_vld=0, state S_ARMED. This is a rebound to the remaining players.
  - Timeout may preempt S_FLASH.
  - A tr_clr in the same cycle wins and suppresses tr_timeout.
- tr_win and tr_timeout never assert in the same cycle. Counters are sized to their maximum values; no wrap-around beyond the terminal count.

Decomposition:
- Package buzzer_pkg: state enum (S_IDLE, S_ARMED, S_FLASH, S_HOLD); width helper CW(N_CH)=max(1,clog2).
- Sub-module prio_pick: combinational fixed/rotating priority selector. Params N_CH, TIE_RR. Ports req[N_CH], ptr[CW], gnt_vld, gnt_idx[CW].
- Flash and answer timers stay in the top level.

Test Plan (all tests use N_CH=4, FLA_CMAX=5, FLA_CNT=2, ANS_CMAX=50 unless stated):
- Early lockout: tr_btn=4'b0100 in S_IDLE → foul=4'b0100, no tr_win. Then tr_arm; ch2 press ignored; ch1 press at t → tr_win at t+1, win_idx=1, led=4'b0010.
- Tie: TIE_RR=0, tr_btn=4'b1010 → win_idx=1. TIE_RR=1: first round 4'b1010 → 1; after tr_clr and tr_arm, 4'b1010 → 3.
- Flash timing: led[idx] is 1 for cycles 1-5, 0 for 6-10, 1 for 11-15, 0 for 16-20, then 1 steady from cycle 21. buzz=1 for exactly cycles 1-20.
- Timeout: no tr_clr → tr_timeout at win+50, foul[idx]=1, led=0, state S_ARMED; the next press on another channel wins. ANS_CMAX=0 → S_HOLD persists indefinitely.
- Clear: tr_clr mid S_FLASH → next cycle led, buzz, win_vld and foul all 0. tr_clr with tr_arm in the same cycle → remains S_IDLE. tr_clr on the timeout cycle → no tr_timeout.
- Reset: rst asserted in S_HOLD → next edge all outputs 0, S_IDLE. With TIE_RR=1, 4'b1111 after re-arm → win_idx=0.
